gift_pipe_output_buffer: RTL and testbench
==========================================

// Module: gift_pipe_output_buffer
// PURPOSE
//  Downstream stage of the pipelined GIFT-128 core. Captures each 128-bit result on the pipe's
//  valid strobe into a small FIFO and streams it out as 32-bit words over a valid/ready port.
//  Tracks blocks in flight and tells the host when a new block may start, so no result is lost.
// PARAMETERS
//  DEPTH    4   FIFO entries of 128 bits; power of two, 2..16
//  WORD_W   32  output word width; fixed, 128/WORD_W = 4 words per block
// PORTS
//  inClk         in   1    clock, all state on rising edge
//  inRstN        in   1    asynchronous active-low reset
//  inStartWr     in   1    block launched into pipe (same strobe as external data write)
//  inDataValid   in   1    pipe result valid (pipe control valid output), 1-cycle pulse
//  inData        in   128  pipe result, sampled when inDataValid=1
//  outCanStart   out  1    1 = host may launch another block
//  outWord       out  32   current output word
//  outWordValid  out  1    outWord valid
//  inWordReady   in   1    consumer accepts outWord when valid & ready
//  outWordLast   out  1    1 on 4th (final) word of a block
//  outOverflow   out  1    1-cycle pulse: result dropped, FIFO full
//  outOvfCount   out  8    dropped-block count (GIFT_OUTBUF_OVF_CNT_EN only)
// BEHAVIOUR
//  Reset: FIFO empty, wr/rd ptrs=0, word idx=0, inflight=0; outWordValid=0, outWordLast=0,
//   outWord=0, outOverflow=0, outCanStart=1, outOvfCount=0. Mid-operation reset discards all.
//  Push: inDataValid=1 and (not full or pop same cycle) -> entry written.
//   inDataValid=1, full, no pop -> data dropped, outOverflow=1 next cycle.
//  Latency: push in cycle N -> outWordValid=1 in N+1 if FIFO was empty.
//  Serialiser: head emitted MSW first: word0=[127:96], word1=[95:64], word2=[63:32], word3=[31:0].
//   idx (2 bit) advances on valid&ready; at idx=3 transfer: pop, idx->0, outWordLast=1 with idx=3.
//   outWord/outWordLast stable while valid & !ready. No bubble between blocks if FIFO non-empty.
//  Serialiser FSM: IDLE (empty) -> STREAM on non-empty; STREAM -> IDLE on last transfer when
//   only that entry remains and no push that cycle; otherwise stays STREAM.
//  Credit: inflight +1 on inStartWr, -1 on inDataValid; both same cycle -> unchanged;
//   saturates at 0 and at DEPTH.
//   outCanStart = (fifo_count + inflight) < DEPTH, registered from next-state values.
//   inStartWr while outCanStart=0 is still counted (host violation; may cause overflow).
//  Count arithmetic: fifo_count and inflight are $clog2(DEPTH)+1 bits; ptrs wrap mod DEPTH.
//  Simultaneous push+pop when full: legal, count unchanged, no overflow.
// CONFIGURATION
//  GIFT_OUTBUF_OVF_CNT_EN defined: outOvfCount port present; +1 per dropped block,
//   saturates at 255, cleared only by reset.
//  Not defined: port absent; outOverflow pulse is the only drop indication.
// STRUCTURE
//  Shared include gift_defines.vh: GIFT_BLOCK_W=128, GIFT_WORD_W=32, GIFT_WORDS_PER_BLOCK=4,
//   serialiser state encodings (IDLE=1'b0, STREAM=1'b1).
//  One sub-module: gift_outbuf_fifo (DEPTH x 128 regs, ptrs, count, full/empty).
//  Serialiser, credit counter and overflow logic live in this module.
// TESTING
//  1 Reset: inRstN=0 mid-stream -> all outputs at reset values immediately, outCanStart=1.
//  2 Single block: start, result 128'h0011..EEFF, ready=1 -> 4 words 00112233,44556677,
//    8899AABB,CCDDEEFF on consecutive cycles, last on 4th, valid 1 cycle after push.
//  3 Backpressure: ready=0 for 5 cycles on word1 -> outWord held 44556677, no word lost.
//  4 Credit: 4 starts, ready=0 -> outCanStart=0 after 4th; one block fully drained -> back to 1.
//  5 Overflow: 5 results, ready=0, DEPTH=4 -> 5th dropped, outOverflow 1 cycle,
//    outOvfCount=1 (macro on); first 4 blocks intact.
//  6 Full + push + pop same cycle (ready=1 on last word) -> accepted, no overflow, order kept.

Source files
------------

// File: rtl/gift_pipe_output_buffer_pkg.sv
// Shared constants, serialiser state encoding and word-select helper for the GIFT-128 output buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gift_pipe_output_buffer_pkg;

    localparam int GIFT_BLOCK_W         = 128;
    localparam int GIFT_WORD_W          = 32;
    localparam int GIFT_WORDS_PER_BLOCK = GIFT_BLOCK_W / GIFT_WORD_W;
    localparam int GIFT_OVF_CNT_W       = 8;

    // Index of the final word of a block (idx counter is 2 bits wide)
    localparam logic [1:0] GIFT_IDX_LAST = 2'(GIFT_WORDS_PER_BLOCK - 1);

    // Serialiser state: IDLE while the FIFO is empty, STREAM while a head block exists
    typedef enum logic {
        SER_IDLE   = 1'b0,
        SER_STREAM = 1'b1
    } ser_state_e;

    // Select word idx of a block, most significant word first
    function automatic logic [GIFT_WORD_W-1:0] block_word(
        input logic [GIFT_BLOCK_W-1:0] blk,
        input logic [1:0]              idx
    );
        logic [GIFT_WORD_W-1:0] w;
        case (idx)
            2'd0:    w = blk[127:96];
            2'd1:    w = blk[95:64];
            2'd2:    w = blk[63:32];
            default: w = blk[31:0];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/gift_outbuf_fifo.sv
// DEPTH x 128-bit result FIFO with wrap-around pointers and an occupancy count.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: none internally; caller must only push when not full or when popping the same cycle.
module gift_outbuf_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 128,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              inClk,
    input  logic              inRstN,
    input  logic              push,
    input  logic [DATA_W-1:0] push_dat,
    input  logic              pop,
    output logic [DATA_W-1:0] head_dat,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // Next-state for storage, pointers (wrap mod DEPTH, DEPTH is a power of two) and count
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // State registers; reset discards every stored entry
    always_ff @(posedge inClk or negedge inRstN) begin
        if (!inRstN) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);

endmodule

// File: rtl/gift_pipe_output_buffer.sv
// Buffers 128-bit GIFT pipe results and streams them as 32-bit words (MSW first); tracks blocks in flight.
// Latency: result pushed in cycle N is presented as word0 in cycle N+1 when the FIFO was empty.
// Backpressure: valid/ready on the word port; host paced by outCanStart; full FIFO drops (outOverflow pulse).
// Optional drop counter port outOvfCount is built when GIFT_OUTBUF_OVF_CNT_EN is defined.
module gift_pipe_output_buffer
    import gift_pipe_output_buffer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int WORD_W = 32
) (
    input  logic                    inClk,
    input  logic                    inRstN,
    input  logic                    inStartWr,
    input  logic                    inDataValid,
    input  logic [GIFT_BLOCK_W-1:0] inData,
    output logic                    outCanStart,
    output logic [WORD_W-1:0]       outWord,
    output logic                    outWordValid,
    input  logic                    inWordReady,
    output logic                    outWordLast,
    output logic                    outOverflow
`ifdef GIFT_OUTBUF_OVF_CNT_EN
    ,
    output logic [GIFT_OVF_CNT_W-1:0] outOvfCount
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int SUM_W = CNT_W + 1;

    // FIFO interface
    logic [GIFT_BLOCK_W-1:0] head_dat;
    logic [CNT_W-1:0]        fifo_cnt;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    push;
    logic                    pop;

    // Serialiser
    ser_state_e  state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic        word_vld;
    logic        xfer;
    logic        drop;
    logic [CNT_W-1:0] fifo_cnt_nxt;

    // Credit and overflow
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [SUM_W-1:0] credit_sum;
    logic             can_start_q, can_start_d;
    logic             ovf_q, ovf_d;
`ifdef GIFT_OUTBUF_OVF_CNT_EN
    logic [GIFT_OVF_CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
`endif

    gift_outbuf_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (GIFT_BLOCK_W),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .inClk    (inClk),
        .inRstN   (inRstN),
        .push     (push),
        .push_dat (inData),
        .pop      (pop),
        .head_dat (head_dat),
        .count    (fifo_cnt),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Word handshake, pop on the last word, push/drop decision and next serialiser state.
    // A push into a full FIFO is accepted only when the head block leaves in the same cycle.
    always_comb begin
        word_vld     = (state_q == SER_STREAM);
        xfer         = word_vld & inWordReady;
        pop          = xfer & (idx_q == GIFT_IDX_LAST) & ~fifo_empty;
        push         = inDataValid & (~fifo_full | pop);
        drop         = inDataValid & fifo_full & ~pop;
        fifo_cnt_nxt = fifo_cnt + CNT_W'(push) - CNT_W'(pop);
        idx_d        = xfer ? (idx_q + 2'd1) : idx_q;
        // STREAM persists across blocks while anything remains, so there is no bubble
        state_d      = (fifo_cnt_nxt != '0) ? SER_STREAM : SER_IDLE;
    end

    // Blocks in flight: +1 on launch, -1 on result, saturating at 0 and DEPTH; host gate from next-state totals
    always_comb begin
        inflight_d = inflight_q;
        if (inStartWr && !inDataValid) begin
            if (inflight_q != CNT_W'(DEPTH)) begin
                inflight_d = inflight_q + CNT_W'(1);
            end
        end else if (inDataValid && !inStartWr) begin
            if (inflight_q != '0) begin
                inflight_d = inflight_q - CNT_W'(1);
            end
        end
        credit_sum  = SUM_W'(fifo_cnt_nxt) + SUM_W'(inflight_d);
        can_start_d = (credit_sum < SUM_W'(DEPTH));
    end

    // Overflow pulse next cycle on a dropped result; optional saturating drop counter
    always_comb begin
        ovf_d = drop;
`ifdef GIFT_OUTBUF_OVF_CNT_EN
        ovf_cnt_d = ovf_cnt_q;
        if (drop && (ovf_cnt_q != {GIFT_OVF_CNT_W{1'b1}})) begin
            ovf_cnt_d = ovf_cnt_q + GIFT_OVF_CNT_W'(1);
        end
`endif
    end

    // Serialiser FSM and word index
    always_ff @(posedge inClk or negedge inRstN) begin
        if (!inRstN) begin
            state_q <= SER_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Credit counter and registered host gate
    always_ff @(posedge inClk or negedge inRstN) begin
        if (!inRstN) begin
            inflight_q  <= '0;
            can_start_q <= 1'b1;
        end else begin
            inflight_q  <= inflight_d;
            can_start_q <= can_start_d;
        end
    end

    // Overflow indication registers
    always_ff @(posedge inClk or negedge inRstN) begin
        if (!inRstN) begin
            ovf_q <= 1'b0;
`ifdef GIFT_OUTBUF_OVF_CNT_EN
            ovf_cnt_q <= '0;
`endif
        end else begin
            ovf_q <= ovf_d;
`ifdef GIFT_OUTBUF_OVF_CNT_EN
            ovf_cnt_q <= ovf_cnt_d;
`endif
        end
    end

    // Word output is derived from registered head/idx only, so it holds steady while stalled
    assign outWordValid = word_vld;
    assign outWord      = word_vld ? WORD_W'(block_word(head_dat, idx_q)) : '0;
    assign outWordLast  = word_vld & (idx_q == GIFT_IDX_LAST);
    assign outCanStart  = can_start_q;
    assign outOverflow  = ovf_q;
`ifdef GIFT_OUTBUF_OVF_CNT_EN
    assign outOvfCount  = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_gift_pipe_output_buffer.sv
// Self-checking bench for gift_pipe_output_buffer: directed scenarios plus randomized traffic vs a queue model.
// Latency: n/a.
// Backpressure: randomized inWordReady.
module tb_gift_pipe_output_buffer;

    localparam int DEPTH = 4;

    logic         inClk = 1'b0;
    logic         inRstN;
    logic         inStartWr;
    logic         inDataValid;
    logic [127:0] inData;
    logic         outCanStart;
    logic [31:0]  outWord;
    logic         outWordValid;
    logic         inWordReady;
    logic         outWordLast;
    logic         outOverflow;
`ifdef GIFT_OUTBUF_OVF_CNT_EN
    logic [7:0]   outOvfCount;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [127:0] mq[$];
    int           m_idx;
    int           m_inflight;
    logic         m_ovf;
    int           m_ovf_cnt;
    logic         m_can;

    gift_pipe_output_buffer #(.DEPTH(DEPTH), .WORD_W(32)) dut (
        .inClk        (inClk),
        .inRstN       (inRstN),
        .inStartWr    (inStartWr),
        .inDataValid  (inDataValid),
        .inData       (inData),
        .outCanStart  (outCanStart),
        .outWord      (outWord),
        .outWordValid (outWordValid),
        .inWordReady  (inWordReady),
        .outWordLast  (outWordLast),
        .outOverflow  (outOverflow)
`ifdef GIFT_OUTBUF_OVF_CNT_EN
        ,
        .outOvfCount  (outOvfCount)
`endif
    );

    always #5 inClk = ~inClk;

    function automatic logic [127:0] rand_blk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [31:0] word_of(input logic [127:0] blk, input int w);
        logic [127:0] s;
        s = blk >> (32 * (3 - w));
        return s[31:0];
    endfunction

    function automatic logic exp_valid();
        return mq.size() != 0;
    endfunction

    function automatic logic [31:0] exp_word();
        if (mq.size() == 0) return 32'h0;
        return word_of(mq[0], m_idx);
    endfunction

    function automatic logic exp_last();
        return (mq.size() != 0) && (m_idx == 3);
    endfunction

    task automatic model_clear();
        mq.delete();
        m_idx      = 0;
        m_inflight = 0;
        m_ovf      = 1'b0;
        m_ovf_cnt  = 0;
        m_can      = 1'b1;
    endtask

    // Advance one clock, updating the model from the inputs applied this cycle
    task automatic tick();
        logic vld, xfer, pop, drop;
        vld  = (mq.size() != 0);
        xfer = vld && inWordReady;
        pop  = xfer && (m_idx == 3);
        drop = inDataValid && (mq.size() == DEPTH) && !pop;
        if (xfer) m_idx = (m_idx + 1) % 4;
        if (pop) void'(mq.pop_front());
        if (inDataValid && !drop) mq.push_back(inData);
        if (inStartWr && !inDataValid) begin
            if (m_inflight < DEPTH) m_inflight++;
        end else if (inDataValid && !inStartWr) begin
            if (m_inflight > 0) m_inflight--;
        end
        m_ovf = drop;
        if (drop && m_ovf_cnt < 255) m_ovf_cnt++;
        m_can = (mq.size() + m_inflight) < DEPTH;
        @(posedge inClk);
        #1;
    endtask

    task automatic idle_inputs();
        inStartWr   = 1'b0;
        inDataValid = 1'b0;
        inData      = '0;
        inWordReady = 1'b0;
    endtask

    task automatic reset_dut();
        idle_inputs();
        inRstN = 1'b0;
        repeat (2) @(posedge inClk);
        #1;
        inRstN = 1'b1;
        model_clear();
    endtask

    task automatic test_reset();
        reset_dut();
        checks++; if (outWordValid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", outWordValid); end
        checks++; if (outWord !== 32'h0) begin failures++; $display("FAIL reset_word got=%h exp=0", outWord); end
        checks++; if (outCanStart !== 1'b1) begin failures++; $display("FAIL reset_canstart got=%b exp=1", outCanStart); end
        // get a block streaming, then reset asynchronously mid-block
        inDataValid = 1'b1; inData = rand_blk(); tick();
        inDataValid = 1'b0; inWordReady = 1'b1; inStartWr = 1'b1; tick();
        inStartWr = 1'b0;
        checks++; if (outWordValid !== 1'b1) begin failures++; $display("FAIL pre_reset_valid got=%b exp=1", outWordValid); end
        #2;
        inRstN = 1'b0;
        #1;
        checks++; if (outWordValid !== 1'b0 || outWordLast !== 1'b0) begin failures++; $display("FAIL async_reset_valid_last got=%b%b exp=00", outWordValid, outWordLast); end
        checks++; if (outWord !== 32'h0 || outOverflow !== 1'b0) begin failures++; $display("FAIL async_reset_word_ovf got=%h/%b exp=0/0", outWord, outOverflow); end
        checks++; if (outCanStart !== 1'b1) begin failures++; $display("FAIL async_reset_canstart got=%b exp=1", outCanStart); end
`ifdef GIFT_OUTBUF_OVF_CNT_EN
        checks++; if (outOvfCount !== 8'd0) begin failures++; $display("FAIL async_reset_ovfcnt got=%0d exp=0", outOvfCount); end
`endif
        idle_inputs();
        @(posedge inClk);
        #1;
        inRstN = 1'b1;
        model_clear();
    endtask

    task automatic test_single_block();
        logic [31:0] exp_w [4];
        exp_w[0] = 32'h00112233; exp_w[1] = 32'h44556677;
        exp_w[2] = 32'h8899AABB; exp_w[3] = 32'hCCDDEEFF;
        reset_dut();
        inStartWr = 1'b1; tick();
        inStartWr = 1'b0;
        inDataValid = 1'b1; inData = 128'h00112233_44556677_8899AABB_CCDDEEFF; inWordReady = 1'b1;
        tick();
        inDataValid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (outWordValid !== 1'b1 || outWord !== exp_w[i]) begin failures++; $display("FAIL single_word%0d got=%b/%h exp=1/%h", i, outWordValid, outWord, exp_w[i]); end
            checks++; if (outWordLast !== (i == 3)) begin failures++; $display("FAIL single_last%0d got=%b exp=%b", i, outWordLast, (i == 3)); end
            tick();
        end
        checks++; if (outWordValid !== 1'b0) begin failures++; $display("FAIL single_done_valid got=%b exp=0", outWordValid); end
        inWordReady = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [127:0] blk;
        blk = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        reset_dut();
        inDataValid = 1'b1; inData = blk; tick();
        inDataValid = 1'b0; inWordReady = 1'b1; tick();
        inWordReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (outWordValid !== 1'b1 || outWord !== 32'h44556677 || outWordLast !== 1'b0) begin failures++; $display("FAIL bp_hold%0d got=%b/%h/%b exp=1/44556677/0", i, outWordValid, outWord, outWordLast); end
            tick();
        end
        inWordReady = 1'b1;
        for (int w = 1; w < 4; w++) begin
            checks++; if (outWord !== word_of(blk, w) || outWordLast !== (w == 3)) begin failures++; $display("FAIL bp_resume%0d got=%h/%b exp=%h/%b", w, outWord, outWordLast, word_of(blk, w), (w == 3)); end
            tick();
        end
        checks++; if (outWordValid !== 1'b0) begin failures++; $display("FAIL bp_done_valid got=%b exp=0", outWordValid); end
        inWordReady = 1'b0;
    endtask

    task automatic test_credit();
        logic [127:0] blk [4];
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            inStartWr = 1'b1; tick();
            checks++; if (outCanStart !== (i < 3)) begin failures++; $display("FAIL credit_start%0d got=%b exp=%b", i, outCanStart, (i < 3)); end
        end
        inStartWr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            blk[i] = rand_blk();
            inDataValid = 1'b1; inData = blk[i]; tick();
            checks++; if (outCanStart !== 1'b0) begin failures++; $display("FAIL credit_result%0d got=%b exp=0", i, outCanStart); end
        end
        inDataValid = 1'b0;
        inWordReady = 1'b1;
        for (int w = 0; w < 4; w++) begin
            tick();
            checks++; if (outCanStart !== (w == 3)) begin failures++; $display("FAIL credit_drain%0d got=%b exp=%b", w, outCanStart, (w == 3)); end
        end
        checks++; if (outWord !== word_of(blk[1], 0)) begin failures++; $display("FAIL credit_next_head got=%h exp=%h", outWord, word_of(blk[1], 0)); end
        inWordReady = 1'b0;
    endtask

    task automatic test_overflow();
        logic [127:0] blk [5];
        reset_dut();
        for (int i = 0; i < 5; i++) begin
            blk[i] = rand_blk();
            inDataValid = 1'b1; inData = blk[i]; tick();
            checks++; if (outOverflow !== (i == 4)) begin failures++; $display("FAIL ovf_pulse%0d got=%b exp=%b", i, outOverflow, (i == 4)); end
        end
        inDataValid = 1'b0; tick();
        checks++; if (outOverflow !== 1'b0) begin failures++; $display("FAIL ovf_pulse_end got=%b exp=0", outOverflow); end
`ifdef GIFT_OUTBUF_OVF_CNT_EN
        checks++; if (outOvfCount !== 8'd1) begin failures++; $display("FAIL ovf_count got=%0d exp=1", outOvfCount); end
`endif
        inWordReady = 1'b1;
        for (int b = 0; b < 4; b++) begin
            for (int w = 0; w < 4; w++) begin
                checks++; if (outWordValid !== 1'b1 || outWord !== word_of(blk[b], w)) begin failures++; $display("FAIL ovf_drain b%0d w%0d got=%b/%h exp=1/%h", b, w, outWordValid, outWord, word_of(blk[b], w)); end
                tick();
            end
        end
        checks++; if (outWordValid !== 1'b0) begin failures++; $display("FAIL ovf_drain_empty got=%b exp=0", outWordValid); end
        inWordReady = 1'b0;
    endtask

    task automatic test_full_push_pop();
        logic [127:0] blk [5];
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            blk[i] = rand_blk();
            inDataValid = 1'b1; inData = blk[i]; tick();
        end
        inDataValid = 1'b0;
        inWordReady = 1'b1;
        repeat (3) tick();
        checks++; if (outWordLast !== 1'b1) begin failures++; $display("FAIL fpp_at_last got=%b exp=1", outWordLast); end
        blk[4] = rand_blk();
        inDataValid = 1'b1; inData = blk[4]; tick();
        inDataValid = 1'b0;
        checks++; if (outOverflow !== 1'b0) begin failures++; $display("FAIL fpp_no_ovf got=%b exp=0", outOverflow); end
        for (int b = 1; b < 5; b++) begin
            for (int w = 0; w < 4; w++) begin
                checks++; if (outWordValid !== 1'b1 || outWord !== word_of(blk[b], w)) begin failures++; $display("FAIL fpp_order b%0d w%0d got=%b/%h exp=1/%h", b, w, outWordValid, outWord, word_of(blk[b], w)); end
                tick();
            end
        end
`ifdef GIFT_OUTBUF_OVF_CNT_EN
        checks++; if (outOvfCount !== 8'd0) begin failures++; $display("FAIL fpp_ovfcnt got=%0d exp=0", outOvfCount); end
`endif
        inWordReady = 1'b0;
    endtask

    task automatic test_random();
        int rdy_pct;
        reset_dut();
        for (int c = 0; c < 3000; c++) begin
            rdy_pct     = ((c / 500) % 2 == 0) ? 25 : 85;
            inStartWr   = ($urandom_range(0, 2) == 0);
            inDataValid = ($urandom_range(0, 2) == 0);
            inData      = rand_blk();
            inWordReady = ($urandom_range(0, 99) < rdy_pct);
            tick();
            checks++; if (outWordValid !== exp_valid() || outWord !== exp_word() || outWordLast !== exp_last()) begin failures++; $display("FAIL rand_word c%0d got=%b/%h/%b exp=%b/%h/%b", c, outWordValid, outWord, outWordLast, exp_valid(), exp_word(), exp_last()); end
            checks++; if (outOverflow !== m_ovf) begin failures++; $display("FAIL rand_ovf c%0d got=%b exp=%b", c, outOverflow, m_ovf); end
            checks++; if (outCanStart !== m_can) begin failures++; $display("FAIL rand_canstart c%0d got=%b exp=%b", c, outCanStart, m_can); end
`ifdef GIFT_OUTBUF_OVF_CNT_EN
            checks++; if (outOvfCount !== 8'(m_ovf_cnt)) begin failures++; $display("FAIL rand_ovfcnt c%0d got=%0d exp=%0d", c, outOvfCount, m_ovf_cnt); end
`endif
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        inRstN = 1'b0;
        model_clear();
        test_reset();
        test_single_block();
        test_backpressure();
        test_credit();
        test_overflow();
        test_full_push_pop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
